// File: rtl/hash_result_scheduler.sv
// Hash result scheduler: round-robin readout of 4-byte nonces from a set of
// hash macros into a small result FIFO for a downstream consumer.
module hash_result_scheduler #(
  parameter int         NUMBER_OF_MACROS = 4,
  parameter logic [5:0] RESULT_BASE      = 6'h20,
  parameter int         RESULT_BYTES     = 4,
  parameter int         FIFO_DEPTH       = 4
) (
  input  logic                        M1_CLK,
  input  logic                        RST_N,
  input  logic                        HASH_EN,
  input  logic [NUMBER_OF_MACROS-1:0] DATA_AVAILABLE,
  output logic [NUMBER_OF_MACROS-1:0] MACRO_RD_SELECT,
  output logic [5:0]                  HASH_ADDR,
  input  logic [7:0]                  DATA_FROM_HASH,
  input  logic                        POP,
  output logic                        RESULT_VALID,
  output logic [2:0]                  RESULT_MACRO,
  output logic [31:0]                 RESULT_NONCE,
  output logic [2:0]                  FIFO_COUNT
);

  typedef enum logic [1:0] {IDLE, READ, PUSH, HOLDOFF} state_t;

  localparam int                        PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [2:0]                DEPTH_L   = 3'(FIFO_DEPTH);
  localparam logic [2:0]                READ_LAST = 3'(RESULT_BYTES);
  localparam logic [2:0]                HOLD_LAST = 3'd1;
  localparam logic [NUMBER_OF_MACROS-1:0] ONE     = NUMBER_OF_MACROS'(1);

  state_t                      state_q, next_state;
  logic [2:0]                  cnt_q;
  logic [2:0]                  grant_q;
  logic [2:0]                  last_grant_q;
  logic [NUMBER_OF_MACROS-1:0] mask_q;
  logic [31:0]                 nonce_q;

  logic [7:0]                  eligible;
  logic                        arb_found;
  logic [2:0]                  arb_idx;
  logic                        launch;
  logic [2:0]                  addr_idx;

  logic [31:0]                 fifo_nonce [FIFO_DEPTH];
  logic [2:0]                  fifo_macro [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]                  count_q;
  logic                        push, pop_ok;

  // Round-robin search for the first unmasked pending macro after last_grant.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    eligible  = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    eligible[NUMBER_OF_MACROS-1:0] = DATA_AVAILABLE & ~mask_q;
    for (int i = 0; i < NUMBER_OF_MACROS; i++) begin
      logic [2:0] cand;
      cand = 3'((int'(last_grant_q) + 1 + i) % NUMBER_OF_MACROS);
      if (!arb_found && eligible[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Next-state logic and macro read interface decode.
  always_comb begin
    next_state      = state_q;
    MACRO_RD_SELECT = '0;
    HASH_ADDR       = '0;
    addr_idx        = '0;
    case (state_q)
      IDLE: begin
        if (HASH_EN && (count_q < DEPTH_L) && arb_found) next_state = READ;
      end
      READ: begin
        // The last READ cycle only collects the final byte; the address holds.
        addr_idx        = (cnt_q == READ_LAST) ? READ_LAST - 3'd1 : cnt_q;
        MACRO_RD_SELECT = ONE << grant_q;
        HASH_ADDR       = RESULT_BASE + {3'b000, addr_idx};
        if (cnt_q == READ_LAST) next_state = PUSH;
      end
      PUSH: begin
        next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign launch = (state_q == IDLE) && (next_state == READ);

  // FSM state, phase counter, arbitration history and nonce capture.
  always_ff @(posedge M1_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= 3'(NUMBER_OF_MACROS - 1);
      mask_q       <= '0;
      nonce_q      <= '0;
    end else begin
      state_q <= next_state;
      cnt_q   <= (next_state != state_q || state_q == IDLE) ? 3'd0 : cnt_q + 3'd1;
      if (launch) begin
        grant_q      <= arb_idx;
        last_grant_q <= arb_idx;
        mask_q       <= mask_q | (ONE << arb_idx);
      end
      // The granted macro stays masked until its clear latency has elapsed.
      if (state_q == HOLDOFF && next_state == IDLE) mask_q <= '0;
      if (state_q == READ) begin
        case (cnt_q)
          3'd1:    nonce_q[7:0]   <= DATA_FROM_HASH;
          3'd2:    nonce_q[15:8]  <= DATA_FROM_HASH;
          3'd3:    nonce_q[23:16] <= DATA_FROM_HASH;
          3'd4:    nonce_q[31:24] <= DATA_FROM_HASH;
          default: ;
        endcase
      end
    end
  end

  assign push   = (state_q == PUSH);
  assign pop_ok = POP && (count_q != 3'd0);

  // FIFO storage; written only in PUSH, which the IDLE gate keeps off a full FIFO.
  always_ff @(posedge M1_CLK) begin
    // NOTE: storage is not reset; the head outputs are gated by the occupancy
    // count, so stale contents are never visible.
    if (push) begin
      fifo_nonce[wr_ptr_q] <= nonce_q;
      fifo_macro[wr_ptr_q] <= grant_q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge M1_CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign RESULT_VALID = (count_q != 3'd0);
  assign RESULT_MACRO = RESULT_VALID ? fifo_macro[rd_ptr_q] : 3'd0;
  assign RESULT_NONCE = RESULT_VALID ? fifo_nonce[rd_ptr_q] : 32'd0;
  assign FIFO_COUNT   = count_q;

endmodule

// File: tb/tb_hash_result_scheduler.sv
// Directed testbench for hash_result_scheduler with a behavioural hash-macro
// read port returning one fixed nonce per macro.
module tb_hash_result_scheduler;

  localparam int NM = 4;

  logic          M1_CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          HASH_EN = 1'b0;
  logic          POP = 1'b0;
  logic [NM-1:0] DATA_AVAILABLE = '0;
  logic [7:0]    DATA_FROM_HASH = 8'hEE;
  logic [NM-1:0] MACRO_RD_SELECT;
  logic [5:0]    HASH_ADDR;
  logic          RESULT_VALID;
  logic [2:0]    RESULT_MACRO;
  logic [31:0]   RESULT_NONCE;
  logic [2:0]    FIFO_COUNT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Nonce held by each macro; byte 0 sits at RESULT_BASE.
  logic [31:0] nonce_tbl [NM] = '{32'hC4B3A291, 32'h04F3E2D1, 32'h44332211, 32'h84736251};

  hash_result_scheduler #(
    .NUMBER_OF_MACROS(NM),
    .RESULT_BASE(6'h20),
    .RESULT_BYTES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .M1_CLK(M1_CLK),
    .RST_N(RST_N),
    .HASH_EN(HASH_EN),
    .DATA_AVAILABLE(DATA_AVAILABLE),
    .MACRO_RD_SELECT(MACRO_RD_SELECT),
    .HASH_ADDR(HASH_ADDR),
    .DATA_FROM_HASH(DATA_FROM_HASH),
    .POP(POP),
    .RESULT_VALID(RESULT_VALID),
    .RESULT_MACRO(RESULT_MACRO),
    .RESULT_NONCE(RESULT_NONCE),
    .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 M1_CLK = ~M1_CLK;

  always @(posedge M1_CLK) cyc <= cyc + 1;

  function automatic logic [NM-1:0] onehot(input int m);
    return NM'(1) << m;
  endfunction

  function automatic logic [7:0] macro_byte(input logic [NM-1:0] sel, input logic [5:0] addr);
    logic [31:0] w;
    int m;
    int b;
    case (sel)
      4'b0001: m = 0;
      4'b0010: m = 1;
      4'b0100: m = 2;
      4'b1000: m = 3;
      default: m = -1;
    endcase
    b = int'(addr) - 32;
    if (m < 0 || b < 0 || b > 3) return 8'hEE;
    w = nonce_tbl[m];
    return w[8*b +: 8];
  endfunction

  // Macro read port: request seen mid-cycle, data returned one cycle later.
  logic [NM-1:0] req_sel = '0;
  logic [5:0]    req_addr = '0;
  always @(negedge M1_CLK) begin
    req_sel  = MACRO_RD_SELECT;
    req_addr = HASH_ADDR;
  end
  always @(posedge M1_CLK) begin
    #1;
    DATA_FROM_HASH = macro_byte(req_sel, req_addr);
  end

  task automatic tick();
    @(posedge M1_CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    HASH_EN = 1'b0;
    POP = 1'b0;
    DATA_AVAILABLE = '0;
    repeat (2) tick();
    RST_N = 1'b1;
  endtask

  // Advance until a READ is visible, bounded; an expired bound counts as a failure.
  task automatic wait_read(input int max_cycles);
    int n;
    n = 0;
    while (MACRO_RD_SELECT == '0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (MACRO_RD_SELECT == '0) begin
      errors++;
      $display("FAIL wait_read: no READ within %0d cycles (select=%b)", n, MACRO_RD_SELECT);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    HASH_EN = 1'b1;
    POP = 1'b1;
    DATA_AVAILABLE = 4'b1111;
    repeat (3) tick();
    checks++; if (MACRO_RD_SELECT !== 4'b0000) begin errors++; $display("FAIL reset_select: got %b expected 0000", MACRO_RD_SELECT); end
    checks++; if (HASH_ADDR !== 6'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", HASH_ADDR); end
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", RESULT_VALID); end
    checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", FIFO_COUNT); end
    checks++; if (RESULT_MACRO !== 3'd0) begin errors++; $display("FAIL reset_macro: got %0d expected 0", RESULT_MACRO); end
    checks++; if (RESULT_NONCE !== 32'd0) begin errors++; $display("FAIL reset_nonce: got %h expected 0", RESULT_NONCE); end
    HASH_EN = 1'b0;
    POP = 1'b0;
    DATA_AVAILABLE = '0;
    RST_N = 1'b1;
    tick();
    checks++; if (MACRO_RD_SELECT !== 4'b0000) begin errors++; $display("FAIL idle_select: got %b expected 0000", MACRO_RD_SELECT); end
  endtask

  task automatic test_single();
    logic [5:0] exp_addr [5] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h23};
    DATA_AVAILABLE = 4'b0100;
    HASH_EN = 1'b1;
    wait_read(10);
    // Pending flag drops during READ; the readout must still complete.
    DATA_AVAILABLE = '0;
    for (int j = 0; j < 5; j++) begin
      checks++; if (MACRO_RD_SELECT !== 4'b0100) begin errors++; $display("FAIL single_select_j%0d: got %b expected 0100", j, MACRO_RD_SELECT); end
      checks++; if (HASH_ADDR !== exp_addr[j]) begin errors++; $display("FAIL single_addr_j%0d: got %h expected %h", j, HASH_ADDR, exp_addr[j]); end
      tick();
    end
    checks++; if (MACRO_RD_SELECT !== 4'b0000) begin errors++; $display("FAIL push_select: got %b expected 0000", MACRO_RD_SELECT); end
    checks++; if (HASH_ADDR !== 6'h00) begin errors++; $display("FAIL push_addr: got %h expected 00", HASH_ADDR); end
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL push_valid_early: got %b expected 0", RESULT_VALID); end
    tick();
    checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", RESULT_VALID); end
    checks++; if (RESULT_MACRO !== 3'd2) begin errors++; $display("FAIL single_macro: got %0d expected 2", RESULT_MACRO); end
    checks++; if (RESULT_NONCE !== 32'h44332211) begin errors++; $display("FAIL single_nonce: got %h expected 44332211", RESULT_NONCE); end
    checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", FIFO_COUNT); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd0 || RESULT_VALID !== 1'b0) begin errors++; $display("FAIL single_pop: count %0d valid %b expected 0 0", FIFO_COUNT, RESULT_VALID); end
    // Popping an empty FIFO is ignored.
    POP = 1'b1;
    tick();
    POP = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL empty_pop: got %0d expected 0", FIFO_COUNT); end
    HASH_EN = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_fairness();
    int exp_m [5] = '{0, 1, 2, 3, 0};
    int prev;
    int start;
    do_reset();
    POP = 1'b1;
    DATA_AVAILABLE = 4'b1111;
    HASH_EN = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_read(20);
      start = cyc;
      checks++; if (MACRO_RD_SELECT !== onehot(exp_m[k])) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", k, MACRO_RD_SELECT, onehot(exp_m[k])); end
      if (k > 0) begin
        checks++; if (start - prev != 9) begin errors++; $display("FAIL fair_spacing_%0d: got %0d expected 9", k, start - prev); end
      end
      prev = start;
      repeat (6) tick();
      checks++; if (RESULT_VALID !== 1'b1 || RESULT_MACRO !== 3'(exp_m[k])) begin errors++; $display("FAIL fair_entry_%0d: valid %b macro %0d expected 1 %0d", k, RESULT_VALID, RESULT_MACRO, exp_m[k]); end
    end
    HASH_EN = 1'b0;
    DATA_AVAILABLE = '0;
    repeat (4) tick();
    POP = 1'b0;
  endtask

  task automatic test_full();
    int busy;
    int n;
    do_reset();
    DATA_AVAILABLE = 4'b1111;
    HASH_EN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_read(20);
      repeat (5) tick();
    end
    busy = 0;
    repeat (12) begin
      tick();
      if (MACRO_RD_SELECT != '0) busy++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL full_hold_idle: got %0d READ cycles expected 0", busy); end
    checks++; if (FIFO_COUNT !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", FIFO_COUNT); end
    checks++; if (RESULT_MACRO !== 3'd0 || RESULT_NONCE !== nonce_tbl[0]) begin errors++; $display("FAIL full_head: macro %0d nonce %h expected 0 %h", RESULT_MACRO, RESULT_NONCE, nonce_tbl[0]); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd3 || RESULT_MACRO !== 3'd1) begin errors++; $display("FAIL full_pop: count %0d macro %0d expected 3 1", FIFO_COUNT, RESULT_MACRO); end
    n = 0;
    while (MACRO_RD_SELECT == '0 && n < 5) begin
      tick();
      n++;
    end
    checks++; if (n > 1 || MACRO_RD_SELECT !== 4'b0001) begin errors++; $display("FAIL full_resume: waited %0d select %b expected <=1 0001", n, MACRO_RD_SELECT); end
    HASH_EN = 1'b0;
    DATA_AVAILABLE = '0;
    repeat (10) tick();
  endtask

  task automatic test_push_pop();
    do_reset();
    DATA_AVAILABLE = 4'b1111;
    HASH_EN = 1'b1;
    wait_read(20);
    repeat (5) tick();
    wait_read(20);
    repeat (5) tick();
    wait_read(20);
    checks++; if (MACRO_RD_SELECT !== 4'b0100) begin errors++; $display("FAIL pp_grant: got %b expected 0100", MACRO_RD_SELECT); end
    HASH_EN = 1'b0;
    DATA_AVAILABLE = '0;
    repeat (5) tick();
    checks++; if (FIFO_COUNT !== 3'd2) begin errors++; $display("FAIL pp_count_before: got %0d expected 2", FIFO_COUNT); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd2) begin errors++; $display("FAIL pp_count_after: got %0d expected 2", FIFO_COUNT); end
    checks++; if (RESULT_MACRO !== 3'd1 || RESULT_NONCE !== nonce_tbl[1]) begin errors++; $display("FAIL pp_head1: macro %0d nonce %h expected 1 %h", RESULT_MACRO, RESULT_NONCE, nonce_tbl[1]); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd1 || RESULT_MACRO !== 3'd2 || RESULT_NONCE !== nonce_tbl[2]) begin errors++; $display("FAIL pp_head2: count %0d macro %0d nonce %h expected 1 2 %h", FIFO_COUNT, RESULT_MACRO, RESULT_NONCE, nonce_tbl[2]); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd0 || RESULT_VALID !== 1'b0) begin errors++; $display("FAIL pp_drain: count %0d valid %b expected 0 0", FIFO_COUNT, RESULT_VALID); end
    repeat (3) tick();
  endtask

  task automatic test_hash_en_drop();
    int busy;
    do_reset();
    DATA_AVAILABLE = 4'b1000;
    HASH_EN = 1'b1;
    wait_read(20);
    checks++; if (MACRO_RD_SELECT !== 4'b1000) begin errors++; $display("FAIL en_grant: got %b expected 1000", MACRO_RD_SELECT); end
    repeat (2) tick();
    HASH_EN = 1'b0;
    repeat (4) tick();
    checks++; if (RESULT_VALID !== 1'b1 || RESULT_MACRO !== 3'd3 || RESULT_NONCE !== nonce_tbl[3]) begin errors++; $display("FAIL en_entry: valid %b macro %0d nonce %h expected 1 3 %h", RESULT_VALID, RESULT_MACRO, RESULT_NONCE, nonce_tbl[3]); end
    busy = 0;
    repeat (20) begin
      tick();
      if (MACRO_RD_SELECT != '0) busy++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL en_no_read: got %0d READ cycles expected 0", busy); end
    checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL en_count: got %0d expected 1", FIFO_COUNT); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    DATA_AVAILABLE = 4'b0010;
    HASH_EN = 1'b1;
    wait_read(20);
    checks++; if (MACRO_RD_SELECT !== 4'b0010) begin errors++; $display("FAIL rm_first_grant: got %b expected 0010", MACRO_RD_SELECT); end
    DATA_AVAILABLE = '0;
    repeat (8) tick();
    checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL rm_pre_count: got %0d expected 1", FIFO_COUNT); end
    DATA_AVAILABLE = 4'b0100;
    wait_read(20);
    checks++; if (MACRO_RD_SELECT !== 4'b0100) begin errors++; $display("FAIL rm_second_grant: got %b expected 0100", MACRO_RD_SELECT); end
    repeat (3) tick();
    RST_N = 1'b0;
    DATA_AVAILABLE = 4'b1111;
    tick();
    checks++; if (MACRO_RD_SELECT !== 4'b0000 || HASH_ADDR !== 6'h00) begin errors++; $display("FAIL rm_read_if: select %b addr %h expected 0000 00", MACRO_RD_SELECT, HASH_ADDR); end
    checks++; if (FIFO_COUNT !== 3'd0 || RESULT_VALID !== 1'b0) begin errors++; $display("FAIL rm_fifo: count %0d valid %b expected 0 0", FIFO_COUNT, RESULT_VALID); end
    checks++; if (RESULT_MACRO !== 3'd0 || RESULT_NONCE !== 32'd0) begin errors++; $display("FAIL rm_head: macro %0d nonce %h expected 0 0", RESULT_MACRO, RESULT_NONCE); end
    RST_N = 1'b1;
    wait_read(5);
    checks++; if (MACRO_RD_SELECT !== 4'b0001) begin errors++; $display("FAIL rm_next_grant: got %b expected 0001", MACRO_RD_SELECT); end
    checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL rm_no_push: got %0d expected 0", FIFO_COUNT); end
    HASH_EN = 1'b0;
    DATA_AVAILABLE = '0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_push_pop();
    test_hash_en_drop();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_result_scheduler.md
HASH_RESULT_SCHEDULER -- requirements
Module: hash_result_scheduler

Interface
REQ-001 Parameter NUMBER_OF_MACROS, default 4, number of hash macros served (2..8).
REQ-002 Parameter RESULT_BASE, default 6'h20, hash-macro address of nonce byte 0.
REQ-003 Parameter RESULT_BYTES, default 4, nonce bytes per result, fixed at 4.
REQ-004 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2).
REQ-005 M1_CLK  in  1  sole clock; all state on the rising edge.
REQ-006 RST_N  in  1  reset, synchronous, active-low.
REQ-007 HASH_EN  in  1  enables launching new readouts.
REQ-008 DATA_AVAILABLE  in  NUMBER_OF_MACROS  per-macro result-pending flags.
REQ-009 MACRO_RD_SELECT  out  NUMBER_OF_MACROS  one-hot read select, or all-zero.
REQ-010 HASH_ADDR  out  6  read address to the selected macro.
REQ-011 DATA_FROM_HASH  in  8  read data, valid one cycle after its address/select.
REQ-012 POP  in  1  consumer removes the head FIFO entry.
REQ-013 RESULT_VALID  out  1  FIFO non-empty.
REQ-014 RESULT_MACRO  out  3  macro index of the head entry.
REQ-015 RESULT_NONCE  out  32  nonce of the head entry; byte 0 occupies bits [7:0].
REQ-016 FIFO_COUNT  out  3  occupied entries, 0..FIFO_DEPTH.

Function
REQ-017 FSM states: IDLE, READ, PUSH, HOLDOFF.
REQ-018 IDLE -> READ when HASH_EN=1, FIFO_COUNT<FIFO_DEPTH, and at least one unmasked DATA_AVAILABLE bit is set; otherwise the FSM stays in IDLE.
REQ-019 Grant is round-robin: the search starts at (last_grant+1) mod NUMBER_OF_MACROS; last_grant resets to NUMBER_OF_MACROS-1, so macro 0 has first priority.
REQ-020 READ lasts exactly 5 cycles, j=0..4; MACRO_RD_SELECT holds the granted one-hot value throughout.
REQ-021 In READ cycle j<4, HASH_ADDR=RESULT_BASE+j; in cycle j=4, HASH_ADDR=RESULT_BASE+3 (held).
REQ-022 In READ cycle j>=1, DATA_FROM_HASH is captured as nonce byte j-1.
REQ-023 READ -> PUSH after cycle 4; PUSH writes {grant index, nonce} to the FIFO tail in one cycle, with MACRO_RD_SELECT=0.
REQ-024 PUSH -> HOLDOFF, which lasts 2 cycles; the granted macro stays masked from arbitration until HOLDOFF ends (covers the macro's read-of-last-byte clear latency); HOLDOFF -> IDLE.
REQ-025 In IDLE, PUSH and HOLDOFF: MACRO_RD_SELECT=0 and HASH_ADDR=0.
REQ-026 Minimum spacing between READ entries is 9 cycles (5 READ + 1 PUSH + 2 HOLDOFF + 1 IDLE).
REQ-027 HASH_EN falling mid-readout does not abort; the current readout completes through HOLDOFF, then the FSM holds in IDLE.
REQ-028 DATA_AVAILABLE deasserting during READ does not abort; the entry is pushed as captured.
REQ-029 FIFO: RESULT_VALID, RESULT_MACRO and RESULT_NONCE reflect the head entry combinationally from registered storage; a pushed entry is visible the cycle after PUSH.
REQ-030 POP with RESULT_VALID=0 is ignored.
REQ-031 Simultaneous push and pop leaves FIFO_COUNT unchanged and performs both operations.
REQ-032 Pointers wrap modulo FIFO_DEPTH.
REQ-033 A push never occurs when full (guaranteed by REQ-018), so there is no overflow path.
REQ-034 The FIFO is first-in first-out in grant order.

Reset
REQ-035 On M1_CLK rise with RST_N=0: state=IDLE, last_grant=NUMBER_OF_MACROS-1, masks cleared, FIFO emptied, capture register=0.
REQ-036 Reset values of outputs: MACRO_RD_SELECT=0, HASH_ADDR=0, RESULT_VALID=0, FIFO_COUNT=0, RESULT_MACRO=0, RESULT_NONCE=0.
REQ-037 Reset asserted mid-READ abandons the readout; no entry is pushed.
REQ-038 Reset overrides POP, HASH_EN and DATA_AVAILABLE.

Verification
REQ-039 Single result: DATA_AVAILABLE=4'b0100, macro returns bytes 11,22,33,44 for addresses 0x20..0x23 -> select=4'b0100, addresses 0x20,21,22,23,23; entry {2, 32'h44332211}; RESULT_VALID=1 the cycle after PUSH.
REQ-040 Fairness: DATA_AVAILABLE=4'b1111 held constant -> grants in order 0,1,2,3,0; READ entries 9 cycles apart.
REQ-041 Full FIFO: 4 results with no POP -> FIFO_COUNT=4, FSM holds IDLE, select=0; one POP -> the fifth readout starts within 2 cycles.
REQ-042 Push with pop: FIFO_COUNT=2, POP asserted in the PUSH cycle -> FIFO_COUNT stays 2, head advances, order preserved.
REQ-043 HASH_EN dropped in READ cycle 2 -> entry still pushed; no further READ while HASH_EN=0 despite DATA_AVAILABLE set.
REQ-044 RST_N=0 in READ cycle 3 -> next cycle all outputs at reset values, FIFO_COUNT=0, and the next grant goes to macro 0.
